// File: rtl/fetch_decode_front_end.sv
// Fetch/decode front end: PC and IF/ID registers plus ID-stage control decode.
// SS forces a bubble on the decode outputs without touching fetch state.
module fetch_decode_front_end #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic               clk,
    input  logic               R,
    input  logic               LE,
    input  logic               SS,
    input  logic [INSTR_W-1:0] rom_instruction,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0] instruction,
    output logic [3:0]         ID_opcode,
    output logic               ID_AM,
    output logic               ID_S_enable,
    output logic               ID_load_instr,
    output logic               ID_RF_enable,
    output logic               ID_Size_enable,
    output logic               ID_RW_enable,
    output logic               ID_Enable_signal,
    output logic               ID_BL_instr,
    output logic               ID_B_instr
);

    typedef struct packed {
        logic [3:0] opcode;
        logic       am;
        logic       s_en;
        logic       load;
        logic       rf_en;
        logic       size_en;
        logic       rw_en;
        logic       mem_en;
        logic       bl;
        logic       b;
    } ctrl_t;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [2:0]         cls;
    ctrl_t              dec;
    ctrl_t              ctrl;

    assign pc_plus4 = pc_q + PC_W'(PC_STEP);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (LE) begin
            pc_d    = pc_plus4;
            instr_d = rom_instruction;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign pc_out      = pc_q;
    assign instruction = instr_q;
    assign cls         = instr_q[27:25];

    // Condition field [31:28] is ignored; class bits pick the format.
    always_comb begin
        dec = '0;
        if (instr_q != '0) begin
            case (cls)
                3'b000, 3'b001: begin
                    dec.opcode = instr_q[24:21];
                    dec.s_en   = instr_q[20];
                    dec.am     = (cls == 3'b001);
                    dec.rf_en  = (instr_q[24:23] != 2'b10);
                end
                3'b010, 3'b011: begin
                    dec.am      = (cls == 3'b010);
                    dec.mem_en  = 1'b1;
                    dec.opcode  = instr_q[23] ? 4'b0100 : 4'b0010;
                    dec.load    = instr_q[20];
                    dec.rw_en   = ~instr_q[20];
                    dec.size_en = instr_q[22];
                    dec.rf_en   = instr_q[20];
                end
                3'b101: begin
                    dec.b     = 1'b1;
                    dec.bl    = instr_q[24];
                    dec.rf_en = instr_q[24];
                end
                default: dec = '0;
            endcase
        end
    end

    always_comb begin
        ctrl = dec;
        if (SS) begin
            ctrl = '0;
        end
    end

    assign ID_opcode        = ctrl.opcode;
    assign ID_AM            = ctrl.am;
    assign ID_S_enable      = ctrl.s_en;
    assign ID_load_instr    = ctrl.load;
    assign ID_RF_enable     = ctrl.rf_en;
    assign ID_Size_enable   = ctrl.size_en;
    assign ID_RW_enable     = ctrl.rw_en;
    assign ID_Enable_signal = ctrl.mem_en;
    assign ID_BL_instr      = ctrl.bl;
    assign ID_B_instr       = ctrl.b;

endmodule

// File: tb/tb_fetch_decode_front_end.sv
// Directed bench for fetch_decode_front_end: table of decode vectors
// plus hand sequences for reset, stall, wrap and bubble.
module tb_fetch_decode_front_end;

    logic        clk;
    logic        R;
    logic        LE;
    logic        SS;
    logic [31:0] rom_instruction;
    logic [7:0]  pc_out;
    logic [7:0]  pc_plus4;
    logic [31:0] instruction;
    logic [3:0]  ID_opcode;
    logic        ID_AM;
    logic        ID_S_enable;
    logic        ID_load_instr;
    logic        ID_RF_enable;
    logic        ID_Size_enable;
    logic        ID_RW_enable;
    logic        ID_Enable_signal;
    logic        ID_BL_instr;
    logic        ID_B_instr;

    int checks = 0;
    int errors = 0;

    fetch_decode_front_end dut (
        .clk              (clk),
        .R                (R),
        .LE               (LE),
        .SS               (SS),
        .rom_instruction  (rom_instruction),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .instruction      (instruction),
        .ID_opcode        (ID_opcode),
        .ID_AM            (ID_AM),
        .ID_S_enable      (ID_S_enable),
        .ID_load_instr    (ID_load_instr),
        .ID_RF_enable     (ID_RF_enable),
        .ID_Size_enable   (ID_Size_enable),
        .ID_RW_enable     (ID_RW_enable),
        .ID_Enable_signal (ID_Enable_signal),
        .ID_BL_instr      (ID_BL_instr),
        .ID_B_instr       (ID_B_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Packed order: opcode, AM, S, load, RF, Size, RW, Enable, BL, B
    function automatic logic [12:0] mk(input logic [3:0] op,
                                       input logic am, input logic s,
                                       input logic ld, input logic rf,
                                       input logic sz, input logic rw,
                                       input logic en, input logic bl,
                                       input logic b);
        return {op, am, s, ld, rf, sz, rw, en, bl, b};
    endfunction

    function automatic logic [12:0] ctrl_now();
        return {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                ID_Size_enable, ID_RW_enable, ID_Enable_signal,
                ID_BL_instr, ID_B_instr};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        ss;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] pc_exp;

    initial begin
        vecs.push_back('{"nop",      32'h00000000, 1'b0,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"adds_imm", 32'hE2921005, 1'b0,
            mk(4'b0100, 1,1,0,1,0,0,0,0,0)});
        vecs.push_back('{"cmp_reg",  32'hE1510002, 1'b0,
            mk(4'b1010, 0,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"ldr_imm",  32'hE5921004, 1'b0,
            mk(4'b0100, 1,0,1,1,0,0,1,0,0)});
        vecs.push_back('{"strb_imm", 32'hE5421004, 1'b0,
            mk(4'b0010, 1,0,0,0,1,1,1,0,0)});
        vecs.push_back('{"bl",       32'hEB000010, 1'b0,
            mk(4'b0000, 0,0,0,1,0,0,0,1,1)});
        vecs.push_back('{"b",        32'hEA000010, 1'b0,
            mk(4'b0000, 0,0,0,0,0,0,0,0,1)});
        vecs.push_back('{"add_reg",  32'hE0821003, 1'b0,
            mk(4'b0100, 0,0,0,1,0,0,0,0,0)});
        vecs.push_back('{"ldr_reg",  32'hE7921003, 1'b0,
            mk(4'b0100, 0,0,1,1,0,0,1,0,0)});
        vecs.push_back('{"mov_reg",  32'hE1A00000, 1'b0,
            mk(4'b1101, 0,0,0,1,0,0,0,0,0)});
        vecs.push_back('{"cmp_imm",  32'hE3500000, 1'b0,
            mk(4'b1010, 1,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"tst_reg",  32'hE1100001, 1'b0,
            mk(4'b1000, 0,1,0,0,0,0,0,0,0)});
        vecs.push_back('{"orr_reg",  32'hE1800001, 1'b0,
            mk(4'b1100, 0,0,0,1,0,0,0,0,0)});
        vecs.push_back('{"cond_ign", 32'h02921005, 1'b0,
            mk(4'b0100, 1,1,0,1,0,0,0,0,0)});
        vecs.push_back('{"cls100",   32'hE8000000, 1'b0,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"cls110",   32'hEC000000, 1'b0,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"cls111",   32'hEE000000, 1'b0,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"ss_ldr",   32'hE5921004, 1'b1,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});
        vecs.push_back('{"ss_bl",    32'hEB000010, 1'b1,
            mk(4'b0000, 0,0,0,0,0,0,0,0,0)});

        R = 1'b1;
        LE = 1'b1;
        SS = 1'b0;
        rom_instruction = 32'hE2921005;
        #1 R = 1'b0;
        #1;
        check("rst_pc", {24'h0, pc_out}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_ctrl", {19'h0, ctrl_now()}, 32'h0);
        step();
        step();
        check("rst_over_le_pc", {24'h0, pc_out}, 32'h0);
        check("rst_over_le_ins", instruction, 32'h0);

        rom_instruction = 32'h0;
        R = 1'b1;
        step();
        check("cnt_pc4", {24'h0, pc_out}, 32'd4);
        step();
        check("cnt_pc8", {24'h0, pc_out}, 32'd8);
        step();
        check("cnt_pc12", {24'h0, pc_out}, 32'd12);
        check("cnt_plus4", {24'h0, pc_plus4}, 32'd16);

        LE = 1'b0;
        rom_instruction = 32'hE5921004;
        step();
        step();
        check("hold_pc", {24'h0, pc_out}, 32'd12);
        check("hold_instr", instruction, 32'h0);

        LE = 1'b1;
        step();
        check("load_instr", instruction, 32'hE5921004);
        check("load_pc", {24'h0, pc_out}, 32'd16);
        #2 R = 1'b0;
        #1;
        check("async_rst_pc", {24'h0, pc_out}, 32'h0);
        check("async_rst_ins", instruction, 32'h0);
        R = 1'b1;

        rom_instruction = 32'h0;
        for (int i = 0; i < 63; i++) step();
        check("wrap_pc252", {24'h0, pc_out}, 32'd252);
        check("wrap_plus4", {24'h0, pc_plus4}, 32'd0);
        step();
        check("wrap_pc0", {24'h0, pc_out}, 32'd0);

        pc_exp = 8'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            rom_instruction = vecs[i].instr;
            SS = vecs[i].ss;
            step();
            pc_exp = pc_exp + 8'd4;
            check({vecs[i].name, "_ins"}, instruction, vecs[i].instr);
            check({vecs[i].name, "_ctl"}, {19'h0, ctrl_now()},
                  {19'h0, vecs[i].exp});
            check({vecs[i].name, "_pc"}, {24'h0, pc_out}, {24'h0, pc_exp});
        end

        SS = 1'b0;
        rom_instruction = 32'hE5921004;
        step();
        pc_exp = pc_exp + 8'd4;
        LE = 1'b0;
        SS = 1'b1;
        rom_instruction = 32'hEA000010;
        step();
        check("stall_bub_ins", instruction, 32'hE5921004);
        check("stall_bub_ctl", {19'h0, ctrl_now()}, 32'h0);
        check("stall_bub_pc", {24'h0, pc_out}, {24'h0, pc_exp});
        SS = 1'b0;
        #1;
        check("unbub_ctl", {19'h0, ctrl_now()},
              {19'h0, mk(4'b0100, 1,0,1,1,0,0,1,0,0)});
        check("unbub_ins", instruction, 32'hE5921004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
